// File: rtl/vid_issue.sv
// vid_issue: beat sequencer for vid.v. It takes one command (base address,
// SEW, vl, v0 mask) and emits one registered beat per unstalled cycle to the
// vALU index generator. It then pulses done together with the last beat.
module vid_issue #(
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int MAX_VL            = 256,
  parameter int VL_WIDTH          = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [REQ_ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [2:0]                   cmd_sew,
  input  logic [VL_WIDTH-1:0]          cmd_vl,
  input  logic                         cmd_vm,
  input  logic [MAX_VL-1:0]            cmd_v0,
  input  logic                         stall,
  output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
  output logic [2:0]                   out_sew,
  output logic [7:0]                   out_start_idx,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_mask,
  output logic                         out_valid,
  output logic                         done
);

  // Width used for element-index arithmetic. It is wide enough for
  // k*EPB + EPB without wrapping for any legal vl.
  localparam int IW = 16;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                         state_q, state_d;

  // Latched command and beat counter k.
  logic [REQ_ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [2:0]                     sew_q, sew_d;
  logic [VL_WIDTH-1:0]            vl_q, vl_d;
  logic                           vm_q, vm_d;
  logic [MAX_VL-1:0]              v0_q, v0_d;
  logic [IW-1:0]                  k_q, k_d;

  // Registered beat outputs.
  logic [REQ_ADDR_WIDTH-1:0]      out_addr_q, out_addr_d;
  logic [2:0]                     out_sew_q, out_sew_d;
  logic [7:0]                     out_start_idx_q, out_start_idx_d;
  logic [REQ_BYTE_EN_WIDTH-1:0]   out_mask_q, out_mask_d;
  logic                           out_valid_q, out_valid_d;
  logic                           done_q, done_d;

  logic                           accept;
  logic                           bad_cmd;
  logic                           issue;
  logic                           last_beat;
  logic [IW-1:0]                  epb;
  logic [IW-1:0]                  base;
  logic [MAX_VL-1:0]              v0_sh;

  // The reset term keeps cmd_ready low while reset is held.
  assign cmd_ready = rst_n && (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // A zero-length command or a reserved SEW completes with no beats.
  assign bad_cmd   = (cmd_vl == '0) || cmd_sew[2];
  assign issue     = (state_q == S_RUN) && !stall;

  // EPB elements per beat. base is the index of element 0 of beat k.
  assign epb       = IW'(REQ_BYTE_EN_WIDTH) >> sew_q;
  assign base      = k_q * epb;
  assign last_beat = (base + epb) >= IW'(vl_q);
  // Align v0 so that bit i belongs to element slot i of the current beat.
  assign v0_sh     = v0_q >> base;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the values that held before the edge.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: latch the command on accept, then advance k once per issued beat.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path through this
    // block can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    sew_d   = sew_q;
    vl_d    = vl_q;
    vm_d    = vm_q;
    v0_d    = v0_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = cmd_addr;
          sew_d  = cmd_sew;
          vl_d   = cmd_vl;
          vm_d   = cmd_vm;
          v0_d   = cmd_v0;
          k_d    = '0;
          if (!bad_cmd) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          k_d = k_q + IW'(1);
          if (last_beat) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: beat fields for the next cycle. All fields are zero when no beat is issued.
  always_comb begin
    out_valid_d     = issue;
    done_d          = (accept && bad_cmd) || (issue && last_beat);
    out_addr_d      = '0;
    out_sew_d       = '0;
    out_start_idx_d = '0;
    out_mask_d      = '0;
    if (issue) begin
      out_addr_d      = addr_q + REQ_ADDR_WIDTH'(k_q);
      out_sew_d       = sew_q;
      out_start_idx_d = base[7:0];
      for (int i = 0; i < REQ_BYTE_EN_WIDTH; i++) begin
        out_mask_d[i] = (IW'(i) < epb) && ((base + IW'(i)) < IW'(vl_q))
                        && (vm_q || v0_sh[i]);
      end
    end
  end

  // Beat output registers. Reset clears them, which also drops any beat in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_addr_q      <= '0;
      out_sew_q       <= '0;
      out_start_idx_q <= '0;
      out_mask_q      <= '0;
      out_valid_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      out_addr_q      <= out_addr_d;
      out_sew_q       <= out_sew_d;
      out_start_idx_q <= out_start_idx_d;
      out_mask_q      <= out_mask_d;
      out_valid_q     <= out_valid_d;
      done_q          <= done_d;
    end
  end

  // Command latch and beat counter.
  always_ff @(posedge clk) begin
    // NOTE: these registers have no reset. They are only read in RUN, and RUN
    // is entered through accept, which loads them first. This keeps reset
    // routing off the wide v0 register.
    addr_q <= addr_d;
    sew_q  <= sew_d;
    vl_q   <= vl_d;
    vm_q   <= vm_d;
    v0_q   <= v0_d;
    k_q    <= k_d;
  end

  assign out_addr      = out_addr_q;
  assign out_sew       = out_sew_q;
  assign out_start_idx = out_start_idx_q;
  assign out_mask      = out_mask_q;
  assign out_valid     = out_valid_q;
  assign done          = done_q;

endmodule
